// File: rtl/mycpu_rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback merged with a long-latency result FIFO.
// Optional forwarding lookup ports are built when MYCPU_RFWA_FWD_EN is defined.
module mycpu_rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic [ADDR_WIDTH-1:0] pipe_waddr,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    output logic                  pipe_stall,
    input  logic                  lr_valid,
    output logic                  lr_ready,
    input  logic [ADDR_WIDTH-1:0] lr_waddr,
    input  logic [DATA_WIDTH-1:0] lr_wdata,
`ifdef MYCPU_RFWA_FWD_EN
    input  logic [ADDR_WIDTH-1:0] fwd_raddr1,
    input  logic [ADDR_WIDTH-1:0] fwd_raddr2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_WIDTH-1:0] fwd_data1,
    output logic [DATA_WIDTH-1:0] fwd_data2,
`endif
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] R0         = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DZ         = {DATA_WIDTH{1'b0}};
    localparam logic [PTR_W:0]        PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [DEPTH];
    logic [DEPTH-1:0]      live_q, live_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic             full_s, empty_s, head_live_s, head_dead_s, head_grant_s;
    logic             push_s, pop_s, pipe_wr_s;
    logic [PTR_W-1:0] head_idx_s, wr_idx_s;

    // Handshake, grant and pop decisions for the current cycle
    always_comb begin
        full_s       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        empty_s      = (wr_ptr_q == rd_ptr_q);
        head_idx_s   = rd_ptr_q[PTR_W-1:0];
        wr_idx_s     = wr_ptr_q[PTR_W-1:0];
        head_live_s  = !empty_s && live_q[head_idx_s];
        head_dead_s  = !empty_s && !live_q[head_idx_s];
        head_grant_s = head_live_s && !pipe_valid;
        pop_s        = head_grant_s || head_dead_s;
        pipe_wr_s    = pipe_valid && (pipe_waddr != R0);
        lr_ready     = !full_s && !rst;
        push_s       = lr_valid && lr_ready && (lr_waddr != R0);
        pipe_stall   = (starve_q == STARVE_LIM);
    end

    // FIFO next state: cancel stale entries first, then the (younger) push overrides its slot
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        live_d      = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_wr_s && (fifo_addr_q[i] == pipe_waddr)) begin
                live_d[i] = 1'b0;
            end else begin
                live_d[i] = live_q[i];
            end
        end
        if (push_s) begin
            fifo_addr_d[wr_idx_s] = lr_waddr;
            fifo_data_d[wr_idx_s] = lr_wdata;
            live_d[wr_idx_s]      = 1'b1;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Starvation counter saturates at the limit so a misbehaving pipe keeps seeing the stall
    always_comb begin
        if (empty_s || head_grant_s) begin
            starve_d = CNT_ZERO;
        end else if (head_live_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Write-port stage contents; r0 pipeline writes occupy the slot but never assert wen
    always_comb begin
        if (pipe_valid) begin
            rf_wen_d   = pipe_wr_s;
            rf_waddr_d = pipe_wr_s ? pipe_waddr : R0;
            rf_wdata_d = pipe_wr_s ? pipe_wdata : DZ;
        end else if (head_grant_s) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = fifo_addr_q[head_idx_s];
            rf_wdata_d = fifo_data_q[head_idx_s];
        end else begin
            rf_wen_d   = 1'b0;
            rf_waddr_d = R0;
            rf_wdata_d = DZ;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {(PTR_W+1){1'b0}};
            rd_ptr_q   <= {(PTR_W+1){1'b0}};
            live_q     <= {DEPTH{1'b0}};
            starve_q   <= CNT_ZERO;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= R0;
            rf_wdata_q <= DZ;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= R0;
                fifo_data_q[i] <= DZ;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            live_q      <= live_d;
            starve_q    <= starve_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef MYCPU_RFWA_FWD_EN
    logic [1:0][ADDR_WIDTH-1:0] fwd_raddr_s;
    logic [1:0]                 fwd_hit_s;
    logic [1:0][DATA_WIDTH-1:0] fwd_data_s;
    logic [PTR_W:0]             occ_s;
    logic [PTR_W-1:0]           fwd_idx_s;

    // Youngest-match lookup: rf stage first, then queue entries from head to tail overwrite it
    always_comb begin
        fwd_raddr_s[0] = fwd_raddr1;
        fwd_raddr_s[1] = fwd_raddr2;
        occ_s          = wr_ptr_q - rd_ptr_q;
        fwd_idx_s      = head_idx_s;
        for (int p = 0; p < 2; p++) begin
            if (rf_wen_q && (rf_waddr_q == fwd_raddr_s[p]) && (fwd_raddr_s[p] != R0)) begin
                fwd_hit_s[p]  = 1'b1;
                fwd_data_s[p] = rf_wdata_q;
            end else begin
                fwd_hit_s[p]  = 1'b0;
                fwd_data_s[p] = DZ;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx_s = head_idx_s + PTR_W'(i);
                if ((OCC_W'(i) < occ_s) && live_q[fwd_idx_s] &&
                    (fifo_addr_q[fwd_idx_s] == fwd_raddr_s[p]) && (fwd_raddr_s[p] != R0)) begin
                    fwd_hit_s[p]  = 1'b1;
                    fwd_data_s[p] = fifo_data_q[fwd_idx_s];
                end else begin
                    fwd_hit_s[p]  = fwd_hit_s[p];
                    fwd_data_s[p] = fwd_data_s[p];
                end
            end
        end
    end

    assign fwd_hit1  = fwd_hit_s[0];
    assign fwd_hit2  = fwd_hit_s[1];
    assign fwd_data1 = fwd_data_s[0];
    assign fwd_data2 = fwd_data_s[1];
`endif

endmodule

// File: tb/tb_mycpu_rf_write_arbiter.sv
// Self-checking bench for mycpu_rf_write_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model. Forwarding checks are built with MYCPU_RFWA_FWD_EN.
module tb_mycpu_rf_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;
    localparam int STARVE_MAX = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pipe_valid = 1'b0;
    logic [AW-1:0] pipe_waddr = 5'd0;
    logic [DW-1:0] pipe_wdata = 32'd0;
    logic          pipe_stall;
    logic          lr_valid = 1'b0;
    logic          lr_ready;
    logic [AW-1:0] lr_waddr = 5'd0;
    logic [DW-1:0] lr_wdata = 32'd0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef MYCPU_RFWA_FWD_EN
    logic [AW-1:0] fwd_raddr1 = 5'd0;
    logic [AW-1:0] fwd_raddr2 = 5'd0;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
`endif

    mycpu_rf_write_arbiter dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_waddr(lr_waddr), .lr_wdata(lr_wdata),
`ifdef MYCPU_RFWA_FWD_EN
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of pending results in arrival order
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; bit live; } ent_t;
    ent_t          m_q[$];
    int            m_starve;
    logic          exp_wen;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;

    task automatic model_reset();
        m_q.delete();
        m_starve  = 0;
        exp_wen   = 1'b0;
        exp_waddr = 5'd0;
        exp_wdata = 32'd0;
    endtask

    task automatic model_step();
        bit   had, live, grant, ready;
        ent_t e;
        had   = (m_q.size() > 0);
        live  = had && m_q[0].live;
        grant = live && !pipe_valid;
        ready = (m_q.size() < DEPTH);
        if (pipe_valid) begin
            exp_wen = (pipe_waddr != 5'd0); exp_waddr = pipe_waddr; exp_wdata = pipe_wdata;
        end else if (grant) begin
            exp_wen = 1'b1; exp_waddr = m_q[0].a; exp_wdata = m_q[0].d;
        end else begin
            exp_wen = 1'b0;
        end
        if (!had || grant) m_starve = 0;
        else if (live && m_starve < STARVE_MAX) m_starve = m_starve + 1;
        if (had && (grant || !live)) void'(m_q.pop_front());
        if (pipe_valid && pipe_waddr != 5'd0) begin
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_q[i].a == pipe_waddr) begin
                    e = m_q[i]; e.live = 1'b0; m_q[i] = e;
                end
            end
        end
        if (lr_valid && ready && lr_waddr != 5'd0) begin
            e.a = lr_waddr; e.d = lr_wdata; e.live = 1'b1;
            m_q.push_back(e);
        end
    endtask

    function automatic logic [DW:0] m_fwd(input logic [AW-1:0] ra);
        logic [DW:0] r;
        r = {1'b0, 32'd0};
        if (ra != 5'd0) begin
            if (exp_wen && exp_waddr == ra) r = {1'b1, exp_wdata};
            foreach (m_q[i]) if (m_q[i].live && m_q[i].a == ra) r = {1'b1, m_q[i].d};
        end
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid = 1'b0; lr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs();
        @(posedge clk); #1;
        n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL reset_wen: got %0b want 0", rf_wen); end
        n_checks++; if (rf_waddr !== 5'd0) begin n_errors++; $display("FAIL reset_waddr: got %0h want 0", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_wdata: got %0h want 0", rf_wdata); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", pipe_stall); end
        n_checks++; if (lr_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %0b want 0", lr_ready); end
        rst = 1'b0; model_reset(); #1;
        n_checks++; if (lr_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready: got %0b want 1", lr_ready); end
    endtask

    task automatic test_pipe_write();
        pipe_valid = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
        tick();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
            n_errors++; $display("FAIL pipe_write: got wen=%0b a=%0d d=%0h want 1/3/11", rf_wen, rf_waddr, rf_wdata); end
        pipe_valid = 1'b0;
        tick();
        n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL pipe_write_idle: got %0b want 0", rf_wen); end
    endtask

    task automatic test_fifo_order();
        for (int k = 0; k < 4; k++) begin
            pipe_valid = 1'b1; pipe_waddr = 5'd1; pipe_wdata = $urandom;
            lr_valid = 1'b1; lr_waddr = 5'(4 + k); lr_wdata = 32'hA4 + 32'(k);
            #1;
            n_checks++; if (lr_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready%0d: got %0b want 1", k, lr_ready); end
            tick();
        end
        idle_inputs(); #1;
        n_checks++; if (lr_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %0b want 0", lr_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(4 + k) || rf_wdata !== 32'hA4 + 32'(k)) begin
                n_errors++; $display("FAIL drain%0d: got wen=%0b a=%0d d=%0h want 1/%0d/%0h",
                                     k, rf_wen, rf_waddr, rf_wdata, 4 + k, 32'hA4 + 32'(k)); end
        end
        tick();
        n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL drain_done: got %0b want 0", rf_wen); end
    endtask

    task automatic test_cancel();
        lr_valid = 1'b1; lr_waddr = 5'd5; lr_wdata = 32'hAA;
        tick();
        n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL cancel_push: got %0b want 0", rf_wen); end
        lr_valid = 1'b0; pipe_valid = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hBB;
        tick();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hBB) begin
            n_errors++; $display("FAIL cancel_pipe: got wen=%0b a=%0d d=%0h want 1/5/bb", rf_wen, rf_waddr, rf_wdata); end
        pipe_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL cancel_stale%0d: got wen=%0b d=%0h want 0", k, rf_wen, rf_wdata); end
        end
    endtask

    task automatic test_starve();
        int denied;
        bit seen;
        pipe_valid = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h2222;
        lr_valid = 1'b1; lr_waddr = 5'd6; lr_wdata = 32'h66;
        tick();
        lr_valid = 1'b0; denied = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (pipe_stall === 1'b1) seen = 1'b1;
            else begin tick(); denied++; end
        end
        n_checks++; if (!seen || denied != STARVE_MAX) begin
            n_errors++; $display("FAIL starve_count: got seen=%0b denied=%0d want 1/%0d", seen, denied, STARVE_MAX); end
        pipe_valid = 1'b0;
        tick();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
            n_errors++; $display("FAIL starve_drain: got wen=%0b a=%0d d=%0h want 1/6/66", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_errors++; $display("FAIL starve_release: got %0b want 0", pipe_stall); end
        // Pipe ignores the stall: it keeps the port and the stall persists until the head drains
        pipe_valid = 1'b1; lr_valid = 1'b1; lr_waddr = 5'd7; lr_wdata = 32'h77;
        tick();
        lr_valid = 1'b0;
        for (int c = 0; c < STARVE_MAX; c++) tick();
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (pipe_stall !== 1'b1) begin n_errors++; $display("FAIL stall_hold%0d: got %0b want 1", c, pipe_stall); end
            tick();
            n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd2) begin
                n_errors++; $display("FAIL stall_pipe_wins%0d: got wen=%0b a=%0d want 1/2", c, rf_wen, rf_waddr); end
        end
        pipe_valid = 1'b0;
        tick();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
            n_errors++; $display("FAIL violation_drain: got wen=%0b a=%0d d=%0h want 1/7/77", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_errors++; $display("FAIL violation_release: got %0b want 0", pipe_stall); end
    endtask

    task automatic test_r0_and_reset();
        pipe_valid = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
        lr_valid = 1'b1; lr_waddr = 5'd0; lr_wdata = 32'hBEEF;
        #1;
        n_checks++; if (lr_ready !== 1'b1) begin n_errors++; $display("FAIL r0_ready: got %0b want 1", lr_ready); end
        tick();
        n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL r0_pipe: got %0b want 0", rf_wen); end
        idle_inputs();
        tick();
        n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL r0_lr: got %0b want 0", rf_wen); end
        for (int k = 0; k < 3; k++) begin
            pipe_valid = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1000 + 32'(k);
            lr_valid = 1'b1; lr_waddr = 5'(10 + k); lr_wdata = 32'hC0 + 32'(k);
            tick();
        end
        idle_inputs();
        n_checks++; if (rf_wen !== 1'b1) begin n_errors++; $display("FAIL pre_reset_wen: got %0b want 1", rf_wen); end
        rst = 1'b1; #1;
        n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL async_reset_wen: got %0b want 0", rf_wen); end
        n_checks++; if (lr_ready !== 1'b0) begin n_errors++; $display("FAIL async_reset_ready: got %0b want 0", lr_ready); end
        @(negedge clk);
        rst = 1'b0; model_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL flushed%0d: got wen=%0b a=%0d want 0", k, rf_wen, rf_waddr); end
        end
    endtask

`ifdef MYCPU_RFWA_FWD_EN
    task automatic test_fwd();
        pipe_valid = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h5;
        lr_valid = 1'b1; lr_waddr = 5'd9; lr_wdata = 32'h1;
        tick();
        lr_wdata = 32'h2;
        tick();
        lr_valid = 1'b0; fwd_raddr1 = 5'd9; fwd_raddr2 = 5'd0; #1;
        n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h2) begin
            n_errors++; $display("FAIL fwd_young: got hit=%0b d=%0h want 1/2", fwd_hit1, fwd_data1); end
        n_checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin
            n_errors++; $display("FAIL fwd_r0: got hit=%0b d=%0h want 0/0", fwd_hit2, fwd_data2); end
        idle_inputs();
        for (int k = 0; k < 3; k++) tick();
    endtask
`endif

    task automatic test_random();
        logic [DW:0] f;
        for (int c = 0; c < 400; c++) begin
            if (m_starve == STARVE_MAX) pipe_valid = ($urandom_range(0, 7) == 0);
            else if (c < 200) pipe_valid = ($urandom_range(0, 3) != 0);
            else pipe_valid = ($urandom_range(0, 1) == 1);
            pipe_waddr = 5'($urandom_range(0, 7)); pipe_wdata = $urandom;
            lr_valid = ($urandom_range(0, 2) != 0);
            lr_waddr = 5'($urandom_range(0, 7)); lr_wdata = $urandom;
`ifdef MYCPU_RFWA_FWD_EN
            fwd_raddr1 = 5'($urandom_range(0, 7)); fwd_raddr2 = 5'($urandom_range(0, 7));
`endif
            #1;
            n_checks++; if (lr_ready !== (m_q.size() < DEPTH)) begin
                n_errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", c, lr_ready, m_q.size() < DEPTH); end
            n_checks++; if (pipe_stall !== (m_starve == STARVE_MAX)) begin
                n_errors++; $display("FAIL rnd_stall@%0d: got %0b want %0b", c, pipe_stall, m_starve == STARVE_MAX); end
`ifdef MYCPU_RFWA_FWD_EN
            f = m_fwd(fwd_raddr1);
            n_checks++; if ({fwd_hit1, fwd_data1} !== f) begin
                n_errors++; $display("FAIL rnd_fwd1@%0d: got %0b/%0h want %0b/%0h", c, fwd_hit1, fwd_data1, f[DW], f[DW-1:0]); end
            f = m_fwd(fwd_raddr2);
            n_checks++; if ({fwd_hit2, fwd_data2} !== f) begin
                n_errors++; $display("FAIL rnd_fwd2@%0d: got %0b/%0h want %0b/%0h", c, fwd_hit2, fwd_data2, f[DW], f[DW-1:0]); end
`else
            f = m_fwd(5'd0);
`endif
            tick();
            n_checks++; if (rf_wen !== exp_wen) begin
                n_errors++; $display("FAIL rnd_wen@%0d: got %0b want %0b", c, rf_wen, exp_wen); end
            else if (exp_wen) begin
                n_checks++; if (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
                    n_errors++; $display("FAIL rnd_write@%0d: got %0d/%0h want %0d/%0h",
                                         c, rf_waddr, rf_wdata, exp_waddr, exp_wdata); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pipe_write();
        test_fifo_order();
        test_cancel();
        test_starve();
        test_r0_and_reset();
`ifdef MYCPU_RFWA_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
